// File: rtl/otg_hpi_pkg.sv
// Shared types and constants for the OTG HPI bus-master sequencer.
package otg_hpi_pkg;

    localparam int CNT_W = 4;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4
    } hpi_state_e;

    localparam logic [1:0] HPI_DATA    = 2'd0;
    localparam logic [1:0] HPI_MAILBOX = 2'd1;
    localparam logic [1:0] HPI_ADDR    = 2'd2;
    localparam logic [1:0] HPI_STATUS  = 2'd3;

    // Down-counter preload for a phase lasting n cycles.
    function automatic cnt_t phase_load(input int unsigned n);
        return cnt_t'(n - 1);
    endfunction

endpackage

// File: rtl/otg_hpi_sequencer_sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/otg_hpi_sequencer.sv
// Converts one Avalon-MM slave access into a single timed HPI cycle for the
// CY7C67200 and synchronizes its interrupt line.
module otg_hpi_sequencer
    import otg_hpi_pkg::*;
#(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 6,
    parameter int unsigned HOLD_CYC   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [15:0] avs_writedata,
    output logic [15:0] avs_readdata,
    output logic        avs_waitrequest,
    output logic [1:0]  hpi_addr,
    output logic        hpi_cs_n,
    output logic        hpi_rd_n,
    output logic        hpi_wr_n,
    output logic [15:0] hpi_data_out,
    output logic        hpi_data_oe,
    input  logic [15:0] hpi_data_in,
    input  logic        hpi_int,
    output logic        irq
);

    hpi_state_e  state_q, state_d;
    cnt_t        cnt_q, cnt_d;
    logic        is_wr_q, is_wr_d;
    logic [1:0]  addr_q, addr_d;
    logic [15:0] dout_q, dout_d;
    logic [15:0] rdata_q, rdata_d;
    logic        cs_n_q, cs_n_d;
    logic        rd_n_q, rd_n_d;
    logic        wr_n_q, wr_n_d;
    logic        oe_q, oe_d;
    logic        wait_q, wait_d;
    logic        active;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        is_wr_d = is_wr_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        rdata_d = rdata_q;

        // A simultaneous read and write resolves to the write.
        case (state_q)
            IDLE: begin
                if (avs_write || avs_read) begin
                    state_d = SETUP;
                    cnt_d   = phase_load(SETUP_CYC);
                    is_wr_d = avs_write;
                    addr_d  = avs_address;
                    dout_d  = avs_writedata;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = STROBE;
                    cnt_d   = phase_load(STROBE_CYC);
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    cnt_d   = phase_load(HOLD_CYC);
                    if (!is_wr_q) begin
                        rdata_d = hpi_data_in;
                    end
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Pin values are decoded from the next state so every output is a
        // plain flop and the strobes cannot glitch.
        active = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
        cs_n_d = !active;
        rd_n_d = !((state_d == STROBE) && !is_wr_d);
        wr_n_d = !((state_d == STROBE) && is_wr_d);
        oe_d   = active && is_wr_d;
        wait_d = (state_d != DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            is_wr_q <= 1'b0;
            addr_q  <= '0;
            dout_q  <= '0;
            rdata_q <= '0;
            cs_n_q  <= 1'b1;
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            oe_q    <= 1'b0;
            wait_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            is_wr_q <= is_wr_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            rdata_q <= rdata_d;
            cs_n_q  <= cs_n_d;
            rd_n_q  <= rd_n_d;
            wr_n_q  <= wr_n_d;
            oe_q    <= oe_d;
            wait_q  <= wait_d;
        end
    end

    sync_2ff u_irq_sync (
        .clk   (clk),
        .reset (reset),
        .d     (hpi_int),
        .q     (irq)
    );

    assign avs_readdata    = rdata_q;
    assign avs_waitrequest = wait_q;
    assign hpi_addr        = addr_q;
    assign hpi_cs_n        = cs_n_q;
    assign hpi_rd_n        = rd_n_q;
    assign hpi_wr_n        = wr_n_q;
    assign hpi_data_out    = dout_q;
    assign hpi_data_oe     = oe_q;

endmodule

// File: tb/tb_otg_hpi_sequencer.sv
// Directed bench for otg_hpi_sequencer with a read-data scoreboard.
module tb_otg_hpi_sequencer;
    import otg_hpi_pkg::*;

    localparam int S = 1, T = 6, H = 2;
    localparam int DONE_C = 1 + S + T + H;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  avs_address = '0;
    logic        avs_read = 1'b0, avs_write = 1'b0;
    logic [15:0] avs_writedata = '0;
    logic [15:0] avs_readdata;
    logic        avs_waitrequest;
    logic [1:0]  hpi_addr;
    logic        hpi_cs_n, hpi_rd_n, hpi_wr_n, hpi_data_oe;
    logic [15:0] hpi_data_out;
    logic [15:0] hpi_data_in = '0;
    logic        hpi_int = 1'b0;
    logic        irq;

    logic        avs2_read = 1'b0, avs2_write = 1'b0;
    logic [15:0] avs2_readdata, hpi2_data_out;
    logic        avs2_waitrequest, hpi2_cs_n, hpi2_rd_n, hpi2_wr_n, hpi2_data_oe, irq2;
    logic [1:0]  hpi2_addr;

    int tests = 0, failed = 0;
    int gcyc = 0, rise_cyc = -1, fall_cyc = -1, r1 = 0, n = 0;
    logic prev_cs = 1'b1;
    logic [15:0] rd_model = '0;
    logic [15:0] sb_q[$];

    always #5 clk = ~clk;

    otg_hpi_sequencer dut (
        .clk(clk), .reset(reset), .avs_address(avs_address), .avs_read(avs_read),
        .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .avs_waitrequest(avs_waitrequest), .hpi_addr(hpi_addr), .hpi_cs_n(hpi_cs_n),
        .hpi_rd_n(hpi_rd_n), .hpi_wr_n(hpi_wr_n), .hpi_data_out(hpi_data_out),
        .hpi_data_oe(hpi_data_oe), .hpi_data_in(hpi_data_in), .hpi_int(hpi_int), .irq(irq)
    );

    otg_hpi_sequencer #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) dut2 (
        .clk(clk), .reset(reset), .avs_address(avs_address), .avs_read(avs2_read),
        .avs_write(avs2_write), .avs_writedata(avs_writedata), .avs_readdata(avs2_readdata),
        .avs_waitrequest(avs2_waitrequest), .hpi_addr(hpi2_addr), .hpi_cs_n(hpi2_cs_n),
        .hpi_rd_n(hpi2_rd_n), .hpi_wr_n(hpi2_wr_n), .hpi_data_out(hpi2_data_out),
        .hpi_data_oe(hpi2_data_oe), .hpi_data_in(hpi_data_in), .hpi_int(hpi_int), .irq(irq2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, gcyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        gcyc++;
        if (!prev_cs && hpi_cs_n) rise_cyc = gcyc;
        if (prev_cs && !hpi_cs_n) fall_cyc = gcyc;
        prev_cs = hpi_cs_n;
    endtask

    task automatic xfer(input logic wr, input logic rd, input logic [1:0] a,
                        input logic [15:0] wd, input logic [15:0] din,
                        input bit chained, input bit keep);
        logic [15:0] exp_rd;
        bit act, strb;
        avs_write = wr; avs_read = rd; avs_address = a;
        avs_writedata = wd; hpi_data_in = din;
        exp_rd = wr ? rd_model : din;
        sb_q.push_back(exp_rd);
        rd_model = exp_rd;
        if (chained) begin
            step();
            chk("gap_cs_n", 32'(hpi_cs_n), 32'(1));
            chk("gap_wait", 32'(avs_waitrequest), 32'(1));
        end
        for (int c = 1; c <= DONE_C; c++) begin
            step();
            act  = (c <= S + T + H);
            strb = (c > S) && (c <= S + T);
            chk("cs_n", 32'(hpi_cs_n), 32'(!act));
            chk("wr_n", 32'(hpi_wr_n), 32'(!(strb && wr)));
            chk("rd_n", 32'(hpi_rd_n), 32'(!(strb && !wr)));
            chk("oe", 32'(hpi_data_oe), 32'(act && wr));
            chk("waitreq", 32'(avs_waitrequest), 32'(c != DONE_C));
            if (act) chk("addr", 32'(hpi_addr), 32'(a));
            if (act && wr) chk("data_out", 32'(hpi_data_out), 32'(wd));
            if (!avs_waitrequest) begin
                if (sb_q.size() > 0) chk("readdata", 32'(avs_readdata), 32'(sb_q.pop_front()));
                else chk("sb_underflow", 32'(1), 32'(0));
                if (!keep) begin avs_write = 1'b0; avs_read = 1'b0; end
            end
        end
        if (!keep) begin
            avs_write = 1'b0; avs_read = 1'b0;
            step();
            chk("idle_cs_n", 32'(hpi_cs_n), 32'(1));
            chk("idle_wait", 32'(avs_waitrequest), 32'(1));
            chk("idle_rdata", 32'(avs_readdata), 32'(rd_model));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values
        step(); step();
        chk("rst_cs_n", 32'(hpi_cs_n), 32'(1));
        chk("rst_rd_n", 32'(hpi_rd_n), 32'(1));
        chk("rst_wr_n", 32'(hpi_wr_n), 32'(1));
        chk("rst_oe", 32'(hpi_data_oe), 32'(0));
        chk("rst_addr", 32'(hpi_addr), 32'(0));
        chk("rst_dout", 32'(hpi_data_out), 32'(0));
        chk("rst_rdata", 32'(avs_readdata), 32'(0));
        chk("rst_wait", 32'(avs_waitrequest), 32'(1));
        chk("rst_irq", 32'(irq), 32'(0));
        reset = 1'b0;
        step();

        // Single write then single read
        xfer(1'b1, 1'b0, HPI_ADDR, 16'h1000, 16'h0000, 1'b0, 1'b0);
        xfer(1'b0, 1'b1, HPI_DATA, 16'h0000, 16'hBEEF, 1'b0, 1'b0);
        hpi_data_in = 16'h0000;
        step(); step();
        chk("rdata_held", 32'(avs_readdata), 32'(16'hBEEF));

        // Back-to-back write then read with requests held by the master
        xfer(1'b1, 1'b0, HPI_ADDR, 16'h2222, 16'h0000, 1'b0, 1'b1);
        r1 = rise_cyc;
        xfer(1'b0, 1'b1, HPI_DATA, 16'h0000, 16'h5A5A, 1'b1, 1'b0);
        chk("b2b_gap", 32'(fall_cyc - r1), 32'(2));

        // Reset in the middle of a write strobe
        avs_write = 1'b1; avs_address = HPI_ADDR; avs_writedata = 16'hCAFE;
        for (int c = 1; c <= 4; c++) step();
        chk("pre_rst_wr_n", 32'(hpi_wr_n), 32'(0));
        #2 reset = 1'b1;
        #1;
        chk("arst_cs_n", 32'(hpi_cs_n), 32'(1));
        chk("arst_wr_n", 32'(hpi_wr_n), 32'(1));
        chk("arst_oe", 32'(hpi_data_oe), 32'(0));
        chk("arst_wait", 32'(avs_waitrequest), 32'(1));
        chk("arst_rdata", 32'(avs_readdata), 32'(0));
        avs_write = 1'b0;
        rd_model = '0;
        step();
        reset = 1'b0;
        prev_cs = hpi_cs_n;
        xfer(1'b0, 1'b1, HPI_STATUS, 16'h0000, 16'h1234, 1'b0, 1'b0);

        // Read and write together: write wins, readdata untouched
        xfer(1'b1, 1'b1, HPI_MAILBOX, 16'h00A5, 16'hFFFF, 1'b0, 1'b0);

        // Short-phase instance: DONE at cycle 4
        avs_address = HPI_MAILBOX; avs_writedata = 16'h0077; avs2_write = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            step();
            chk("p111_wait", 32'(avs2_waitrequest), 32'(c != 4));
            chk("p111_cs_n", 32'(hpi2_cs_n), 32'(!(c <= 3)));
            chk("p111_wr_n", 32'(hpi2_wr_n), 32'(c != 2));
            chk("p111_rd_n", 32'(hpi2_rd_n), 32'(1));
            chk("p111_oe", 32'(hpi2_data_oe), 32'(c <= 3));
            if (!avs2_waitrequest) avs2_write = 1'b0;
        end
        avs2_write = 1'b0;
        chk("p111_addr", 32'(hpi2_addr), 32'(HPI_MAILBOX));
        chk("p111_dout", 32'(hpi2_data_out), 32'(16'h0077));
        chk("p111_rdata", 32'(avs2_readdata), 32'(0));

        // Interrupt synchronizer latency, both edges
        chk("irq_idle", 32'(irq), 32'(0));
        #2 hpi_int = 1'b1;
        n = 0;
        while (irq == 1'b0 && n < 6) begin step(); n++; end
        chk("irq_rise_lat", 32'(n >= 2 && n <= 3), 32'(1));
        chk("irq2_high", 32'(irq2), 32'(1));
        #2 hpi_int = 1'b0;
        n = 0;
        while (irq == 1'b1 && n < 6) begin step(); n++; end
        chk("irq_fall_lat", 32'(n >= 2 && n <= 3), 32'(1));
        chk("irq2_low", 32'(irq2), 32'(0));

        chk("sb_empty", 32'(sb_q.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
